pwm_decoder: RTL
================

# pwm_decoder

Measures the duty cycle of an incoming PWM waveform over fixed windows of PERIOD clocks, quantizes it to deciles, and returns the result as an ASCII digit byte 'h30..'h39. It is the receive-side counterpart of the digit-driven PWM generator. The byte goes out on a valid/ready handshake toward the UART transmit path, so a host can read back the duty level it commanded.

## Interface
- PERIOD, 50_000, measurement window length in clk cycles; matches the generator's period.
- STEP, 5_000, clk cycles of high time per decile; must equal PERIOD/10.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM waveform to measure.
- out_data  output  8  ASCII digit 'h30..'h39 of the last completed measurement.
- out_valid  output  1  out_data holds an unaccepted byte.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready on a clk edge.
- level  output  4  decile 0..9 of the last completed window; always updated, independent of the handshake.
- overrun  output  1  one-cycle pulse when a pending, unaccepted byte is replaced.

## Operation
- pwm_in passes through a 2-flop synchronizer to give pwm_s. Measurement uses only pwm_s.
- win_cnt counts 0..PERIOD-1 and wraps. Width is clog2(PERIOD) bits.
- In each cycle where pwm_s=1 inside the window:
  - step_cnt increments.
  - When step_cnt reaches STEP-1 it wraps to 0 and dec_cnt increments.
  - dec_cnt saturates at 9.
- No divider. digit = min(floor(high_cycles/STEP), 9).
- Window end is the cycle with win_cnt==PERIOD-1, and that cycle's sample is included. At window end:
  - level <= dec_cnt, including any increment from this final sample.
  - step_cnt and dec_cnt clear.
  - The candidate byte is 'h30 + level.
- Emission at window end:
  - If out_valid=0, or the byte is accepted in this same cycle: out_data <= candidate, out_valid <= 1.
  - If out_valid=1 and out_ready=0: out_data <= candidate, out_valid stays 1, overrun pulses high for 1 cycle. The newest value always wins.
- Accept: out_valid && out_ready with no window end in that cycle gives out_valid <= 0 next cycle.
- out_data is stable while out_valid=1, except on the overrun replacement above.
- Reset mid-window: all counters clear and the partial window is discarded. The first valid result appears PERIOD cycles after rst_n deasserts.

## Timing
- Reset values:
  - out_data='h30, out_valid=0, level=0, overrun=0.
  - win_cnt, step_cnt and dec_cnt are 0. Synchronizer flops are 0.
- Input latency: 2 cycles from a pwm_in edge to pwm_s.
- Output latency: level, out_data and out_valid update on the clock edge that ends the window at win_cnt==PERIOD-1. They are visible the following cycle.
- A window end and an accept in the same cycle count as an accept followed by a reload. overrun stays 0 and out_valid stays 1.
- Throughput: at most one byte per PERIOD cycles.
- Windows are free-running and are not aligned to pwm_in edges. A phase offset to the source changes high_cycles by at most the synchronizer delay, and the STEP margin absorbs it.

## Configuration
- PWM_DEC_CHANGE_ONLY_EN defined:
  - A byte is emitted only when the new level differs from the last emitted level. The last emitted level resets to 0.
  - level still updates every window.
  - Overrun applies only to emitted bytes.
- Not defined: a byte is emitted every window, as described in Operation.

## Test plan
- **Reset:** hold rst_n=0 while pwm_in toggles. Expect out_valid=0, out_data='h30, level=0. Release, then keep pwm_in=0 for 1 window. Expect out_data='h30 and level=0 at window end.
- **Decile sweep:** drive a PWM with period 50_000 and high time 5_001, 25_001, 45_001 cycles, out_ready=1. Expect bytes 'h31, 'h35, 'h39 in the windows after each setting settles.
- **Saturation:** hold pwm_in=1 constantly. Expect level=9 and out_data='h39, never 'h3A.
- **Backpressure/overrun:** out_ready=0 across two window ends with duty 30% then 70%. Expect out_valid to stay 1, an overrun pulse at the second window end, and out_data='h37. Then raise out_ready for 1 cycle and expect out_valid=0 next cycle.
- **Simultaneous accept and window end:** assert out_ready exactly at win_cnt==PERIOD-1. Expect overrun=0, out_valid=1 and the new byte loaded.
- **Change-only (PWM_DEC_CHANGE_ONLY_EN):** hold 40% duty for 3 windows, then 60%. Expect exactly one 'h34 and then one 'h36; level updates every window.

Source files
------------

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures PWM duty over free-running PERIOD windows and
// emits the decile as an ASCII digit; PWM_DEC_CHANGE_ONLY_EN emits on change only.
module pwm_decoder #(
  parameter int PERIOD = 50_000,
  parameter int STEP   = 5_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] level,
  output logic       overrun
);

  localparam int WW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [WW-1:0] WIN_LAST  = WW'(PERIOD - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);
  localparam logic [3:0]    DEC_MAX   = 4'd9;

  logic          sync1_q, pwm_s_q;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d, step_nx;
  logic [3:0]    dec_cnt_q, dec_cnt_d, dec_nx;
  logic [3:0]    level_q, level_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          win_end, emit;
  logic [7:0]    cand;

  // two-flop synchronizer for the asynchronous PWM input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      pwm_s_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      pwm_s_q <= sync1_q;
    end
  end

  // window, step and decile counters; the last sample of a window counts
  always_comb begin
    win_end   = (win_cnt_q == WIN_LAST);
    win_cnt_d = win_end ? '0 : win_cnt_q + WW'(1);
    step_nx   = step_cnt_q;
    dec_nx    = dec_cnt_q;
    if (pwm_s_q) begin
      if (step_cnt_q == STEP_LAST) begin
        step_nx = '0;
        if (dec_cnt_q != DEC_MAX)
          dec_nx = dec_cnt_q + 4'd1;
      end else begin
        step_nx = step_cnt_q + SW'(1);
      end
    end
    step_cnt_d = win_end ? '0 : step_nx;
    dec_cnt_d  = win_end ? '0 : dec_nx;
    level_d    = win_end ? dec_nx : level_q;
    cand       = 8'h30 + {4'h0, dec_nx};
  end

`ifdef PWM_DEC_CHANGE_ONLY_EN
  logic [3:0] last_q, last_d;

  assign emit = win_end && (dec_nx != last_q);

  // remembers the level of the most recently emitted byte
  always_comb begin
    last_d = last_q;
    if (emit)
      last_d = dec_nx;
  end

  // last emitted level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= 4'd0;
    else
      last_q <= last_d;
  end
`else
  assign emit = win_end;
`endif

  // output handshake: a reload wins over an accept, newest byte wins
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (emit) begin
      out_data_d  = cand;
      out_valid_d = 1'b1;
      overrun_d   = out_valid_q && !out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // measurement and output state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      step_cnt_q  <= '0;
      dec_cnt_q   <= 4'd0;
      level_q     <= 4'd0;
      out_data_q  <= 8'h30;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      step_cnt_q  <= step_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overrun   = overrun_q;

endmodule
